// File: rtl/cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cpu_mem_responder
// Brief    : Single-outstanding data-memory responder for the cpu load/store
//            port. Requests are serviced from an internal word array after a
//            fixed number of wait states, and the response is held until the
//            cpu takes it.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // The wait counter is loaded with the full wait count so that the commit
    // edge lands exactly WAIT_CYCLES+1 edges after the accept edge, including
    // the zero-wait case (one pass through WAIT with the counter already 0).
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          state;
    logic [3:0]          wait_cnt;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NBYTES-1:0]   be_q;

    // Storage is deliberately left without reset: contents survive reset.
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                commit;
    logic                in_range;
    logic [IDX_W-1:0]    idx;

    assign accept   = (state == ST_IDLE) && req_valid && req_ready;
    assign commit   = (state == ST_WAIT) && (wait_cnt == 4'd0);
    assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));
    assign idx      = addr_q[IDX_W-1:0];

    // Request/response control FSM; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        wait_cnt  <= WAIT_INIT;
                        state     <= ST_WAIT;
                    end else begin
                        // Also raises ready on the first edge after reset.
                        req_ready <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= !in_range;
                        rsp_rdata <= (!we_q && in_range) ? mem[idx] : '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Byte-masked array write on the commit edge; an asynchronous reset
    // forces the FSM out of WAIT, so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (commit && we_q && in_range) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_mem_responder
// Brief    : Self-checking bench. Instance 0: DEPTH=200, WAIT_CYCLES=2.
//            Instance 1: DEPTH=256, WAIT_CYCLES=0. A word-level memory model
//            supplies the expected read data, error flags and latencies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int checks = 0;
    int errors = 0;

    // Per-instance geometry: accept-to-valid latency and implemented depth.
    int lat   [2] = '{3, 1};
    int depth [2] = '{200, 256};

    // Reference memory: word value plus "value is known" flag.
    logic [31:0] model [2][256];
    bit          known [2][256];

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (wd & mask);
    endfunction

    // One complete transaction on instance s, entered and left at a negedge.
    // hold = number of cycles rsp_ready stays low after rsp_valid rises.
    task automatic txn(input int s, input bit we, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input int hold, output logic [31:0] got);
        logic [31:0] exp_d;
        bit          inr;
        bit          data_known;
        int          n;
        string       p;
        p   = $sformatf("u%0d_%s_a%0d", s, we ? "wr" : "rd", addr);
        inr = (int'(addr) < depth[s]);

        n = 0;
        while (req_ready[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({p, "_ready_before_accept"}, {31'd0, req_ready[s]}, 32'd1);

        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wd;
        req_be[s]    = be;

        // Expected response from the model, then commit the write in the model.
        data_known = 1'b1;
        if (we || !inr) begin
            exp_d = 32'd0;
        end else begin
            exp_d      = model[s][addr];
            data_known = known[s][addr];
        end
        if (we && inr) begin
            if (known[s][addr] || be == 4'hF) begin
                model[s][addr] = merge(model[s][addr], wd, be);
                known[s][addr] = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        req_valid[s] = 1'b0;
        rsp_ready[s] = (hold == 0);
        chk({p, "_ready_drop"}, {31'd0, req_ready[s]}, 32'd0);

        for (int k = 1; k <= lat[s]; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end else if (lat[s] > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s_valid_edge%0d", p, k), {31'd0, rsp_valid[s]},
                (k == lat[s]) ? 32'd1 : 32'd0);
        end

        got = rsp_rdata[s];
        chk({p, "_err"}, {31'd0, rsp_err[s]}, {31'd0, !inr});
        if (data_known) chk({p, "_rdata"}, rsp_rdata[s], exp_d);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_hold%0d_valid", p, h), {31'd0, rsp_valid[s]}, 32'd1);
            chk($sformatf("%s_hold%0d_rdata", p, h), rsp_rdata[s], got);
            chk($sformatf("%s_hold%0d_ready", p, h), {31'd0, req_ready[s]}, 32'd0);
        end
        rsp_ready[s] = 1'b1;

        @(posedge clk);
        #1;
        rsp_ready[s] = 1'b0;
        chk({p, "_post_valid"}, {31'd0, rsp_valid[s]}, 32'd0);
        chk({p, "_post_rdata"}, rsp_rdata[s], 32'd0);
        chk({p, "_post_err"}, {31'd0, rsp_err[s]}, 32'd0);
        chk({p, "_post_ready"}, {31'd0, req_ready[s]}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [7:0]  a;
        for (int s = 0; s < 2; s++) begin
            reset[s] = 1'b0; req_valid[s] = 1'b0; req_we[s] = 1'b0; req_addr[s] = '0;
            req_wdata[s] = '0; req_be[s] = '0; rsp_ready[s] = 1'b0;
            for (int i = 0; i < 256; i++) begin
                model[s][i] = '0;
                known[s][i] = 1'b0;
            end
        end

        // Reset held for 10 cycles.
        repeat (10) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("u%0d_rst_req_ready", s), {31'd0, req_ready[s]}, 32'd0);
            chk($sformatf("u%0d_rst_rsp_valid", s), {31'd0, rsp_valid[s]}, 32'd0);
            chk($sformatf("u%0d_rst_rsp_rdata", s), rsp_rdata[s], 32'd0);
            chk($sformatf("u%0d_rst_rsp_err", s), {31'd0, rsp_err[s]}, 32'd0);
            reset[s] = 1'b1;
        end
        #1;
        chk("u0_release_before_edge", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++)
            chk($sformatf("u%0d_release_ready", s), {31'd0, req_ready[s]}, 32'd1);
        @(negedge clk);

        // Full write, read-back, partial write, be=0 write, held response.
        for (int s = 0; s < 2; s++) begin
            txn(s, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 0, got);
            txn(s, 1'b0, 8'd5, 32'h0, 4'h0, 0, got);
            chk($sformatf("u%0d_full_write_readback", s), got, 32'hDEADBEEF);
            txn(s, 1'b1, 8'd5, 32'h11223344, 4'b0101, 0, got);
            txn(s, 1'b0, 8'd5, 32'h0, 4'h0, 0, got);
            chk($sformatf("u%0d_byte_enable_merge", s), got, 32'hDE22BE44);
            txn(s, 1'b1, 8'd5, 32'hFFFFFFFF, 4'h0, 0, got);
            txn(s, 1'b0, 8'd5, 32'h0, 4'h0, 6, got);
            chk($sformatf("u%0d_be0_unchanged_held", s), got, 32'hDE22BE44);
        end

        // Out-of-range on the 200-deep instance leaves other words intact.
        txn(0, 1'b1, 8'd10, 32'hCAFEF00D, 4'hF, 0, got);
        txn(0, 1'b1, 8'd210, 32'h12345678, 4'hF, 1, got);
        txn(0, 1'b0, 8'd210, 32'h0, 4'h0, 0, got);
        txn(0, 1'b0, 8'd10, 32'h0, 4'h0, 0, got);
        chk("u0_after_oor_addr10", got, 32'hCAFEF00D);

        // Reset half a cycle after accepting a write aborts it.
        txn(0, 1'b1, 8'd7, 32'hA5A5A5A5, 4'hF, 0, got);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'd7;
        req_wdata[0] = 32'h5A5A5A5A; req_be[0] = 4'hF;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset[0] = 1'b0;
        #1;
        chk("u0_midreset_ready", {31'd0, req_ready[0]}, 32'd0);
        chk("u0_midreset_valid", {31'd0, rsp_valid[0]}, 32'd0);
        repeat (3) @(negedge clk);
        chk("u0_midreset_still_idle", {31'd0, rsp_valid[0]}, 32'd0);
        reset[0] = 1'b1;
        txn(0, 1'b0, 8'd7, 32'h0, 4'h0, 0, got);
        chk("u0_aborted_write_old_value", got, 32'hA5A5A5A5);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            int s;
            s = i % 2;
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(180, 255))
                                            : 8'($urandom_range(0, 15));
            txn(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
